// File: rtl/alarme_pkg.sv
// rtl/alarme_pkg.sv - state encoding and default parameters for the vault alarm
package alarme_pkg;

  typedef enum logic [1:0] {
    DESARMADO  = 2'd0,
    ARMADO     = 2'd1,
    PRE_ALARME = 2'd2,
    ALARME     = 2'd3
  } estado_t;

  localparam int NCH_DEF  = 4;
  localparam int NDEB_DEF = 2;
  localparam int NDLY_DEF = 8;

endpackage

// File: rtl/filtro_porta.sv
// rtl/filtro_porta.sv - single-channel door sensor debounce
module filtro_porta #(
  parameter int NDEB = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic porta,
  output logic aberta
);

  localparam int CW = $clog2(NDEB + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDEB);

  logic [CW-1:0] cnt;

  // Any closed sample restarts the count; the count saturates once the door is trusted open.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt <= '0;
    end else if (!porta) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign aberta = (cnt == CNT_MAX);

endmodule

// File: rtl/alarme_cofre.sv
// rtl/alarme_cofre.sv - vault door alarm: debounced channels, arm/grace/alarm FSM
module alarme_cofre
  import alarme_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int NDEB = NDEB_DEF,
  parameter int NDLY = NDLY_DEF
) (
  input  logic           clk_2,
  input  logic           reset,
  input  logic [NCH-1:0] porta,
  input  logic           expediente,
  input  logic           interruptor,
  input  logic           ack,
  output logic           alarme,
  output logic           pre_alarme,
  output logic           armado,
  output logic [NCH-1:0] canal_disparo,
  output logic [1:0]     estado
);

  localparam int TW = $clog2(NDLY + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(NDLY - 1);

  logic [NCH-1:0] aberta;
  logic           aberta_any;
  estado_t        state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [NCH-1:0] canal_nxt;

  for (genvar i = 0; i < NCH; i++) begin : g_filtro
    filtro_porta #(.NDEB(NDEB)) u_filtro (
      .clk_2  (clk_2),
      .reset  (reset),
      .porta  (porta[i]),
      .aberta (aberta[i])
    );
  end

  assign aberta_any = |aberta;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state         <= DESARMADO;
      timer         <= '0;
      canal_disparo <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      canal_disparo <= canal_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      DESARMADO: begin
        if (interruptor) state_nxt = ARMADO;
      end
      ARMADO: begin
        if (!interruptor) begin
          state_nxt = DESARMADO;
        end else if (aberta_any && expediente) begin
          state_nxt = PRE_ALARME;
          timer_nxt = TIMER_LOAD;
        end else if (aberta_any) begin
          state_nxt = ALARME;
        end
      end
      PRE_ALARME: begin
        if (!interruptor)      state_nxt = DESARMADO;
        else if (!aberta_any)  state_nxt = ARMADO;
        else if (!expediente)  state_nxt = ALARME;
        else if (timer == '0)  state_nxt = ALARME;
        else                   timer_nxt = timer - 1'b1;
      end
      ALARME: begin
        // Disarming alone never silences the siren; the door must be shut and acknowledged.
        if (ack && !aberta_any) state_nxt = interruptor ? ARMADO : DESARMADO;
      end
      default: state_nxt = DESARMADO;
    endcase

    if (state_nxt == PRE_ALARME || state_nxt == ALARME) canal_nxt = canal_disparo | aberta;
    else                                                canal_nxt = '0;
  end

  always_comb begin
    alarme     = (state == ALARME);
    pre_alarme = (state == PRE_ALARME);
    armado     = (state != DESARMADO);
    estado     = state;
  end

endmodule

// File: doc/alarme_cofre.md
ALARME_COFRE -- requirements
Module: alarme_cofre

Interface
REQ-001 Parameter NCH, default 4: number of vault-door channels, 1..16.
REQ-002 Parameter NDEB, default 2: debounce length in cycles, 1..15.
REQ-003 Parameter NDLY, default 8: business-hours grace period in cycles, 1..255.
REQ-004 clk_2  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 porta  input  NCH: raw door-open sensors, 1 = open.
REQ-007 expediente  input  1: 1 = business hours (clock switch).
REQ-008 interruptor  input  1: arm switch, 1 = armed request.
REQ-009 ack  input  1: operator acknowledge, level-sampled.
REQ-010 alarme  output  1: siren, 1 in ALARME.
REQ-011 pre_alarme  output  1: warning lamp, 1 in PRE_ALARME.
REQ-012 armado  output  1: 1 in any state except DESARMADO.
REQ-013 canal_disparo  output  NCH: latched channels that caused pre-alarm/alarm.
REQ-014 estado  output  2: encoded FSM state for LED/LCD display.

Function
REQ-015 Debounce per channel: counter increments each cycle porta[i]=1, saturating at NDEB; any 0 sample clears counter; aberta[i]=1 when counter==NDEB.
REQ-016 aberta_any = OR of aberta[NCH-1:0]; FSM uses only debounced values.
REQ-017 FSM states DESARMADO=0, ARMADO=1, PRE_ALARME=2, ALARME=3; outputs Moore-decoded from registered state.
REQ-018 DESARMADO: interruptor=1 -> ARMADO; else stay.
REQ-019 ARMADO: interruptor=0 -> DESARMADO; else aberta_any & expediente -> PRE_ALARME with timer loaded NDLY-1; aberta_any & ~expediente -> ALARME.
REQ-020 PRE_ALARME priority: interruptor=0 -> DESARMADO; ~aberta_any -> ARMADO; ~expediente -> ALARME; timer==0 -> ALARME; else timer decrements.
REQ-021 PRE_ALARME therefore lasts exactly NDLY cycles when door held open in business hours.
REQ-022 ALARME: leaves only when ack=1 and aberta_any=0 -> ARMADO if interruptor=1, else DESARMADO; interruptor=0 alone does not clear.
REQ-023 canal_disparo: OR-accumulates aberta each cycle the next state is PRE_ALARME or ALARME; cleared when next state is ARMADO or DESARMADO.
REQ-024 Latency: door sampled high at NDEB consecutive edges -> aberta high after that edge -> state change visible after the following edge (NDEB+1 edges total).
REQ-025 Timer width clog2(NDLY+1); no wrap: decrement never occurs at 0.
REQ-026 Simultaneous ack and new door opening in ALARME: remains ALARME.

Reset
REQ-027 reset=1 at an edge forces state DESARMADO, all debounce counters 0, timer 0, canal_disparo 0.
REQ-028 Reset values: alarme=0, pre_alarme=0, armado=0, canal_disparo=0, estado=0.
REQ-029 reset mid-alarm or mid-grace aborts immediately; reset has priority over all inputs.

Structure
REQ-030 Package alarme_pkg holds state enum (estado_t), default parameter constants and state encodings.
REQ-031 One sub-module filtro_porta (single-channel debounce, parameter NDEB), instantiated NCH times via generate.
REQ-032 FSM, timer and canal_disparo latch reside in alarme_cofre; no other hierarchy.

Verification (NCH=4, NDEB=2, NDLY=8)
REQ-033 interruptor=1, expediente=0, porta=0001 held -> alarme=1 after 3rd edge, canal_disparo=0001.
REQ-034 interruptor=1, expediente=1, porta=0100 held -> pre_alarme=1 for 8 cycles, then alarme=1, canal_disparo=0100.
REQ-035 porta=0010 glitch for 1 cycle while ARMADO -> no state change, canal_disparo=0000.
REQ-036 In PRE_ALARME, door closes on cycle 4 -> ARMADO, canal_disparo cleared; expediente drop in PRE_ALARME -> ALARME next edge.
REQ-037 In ALARME, ack=1 with porta=1000 still open -> stays ALARME; close door, ack=1, interruptor=0 -> DESARMADO, estado=0.
REQ-038 reset=1 during ALARME -> next edge all outputs 0, then porta=0000, interruptor=1 -> ARMADO.
